// File: rtl/uart_pkg.sv
// Shared UART definitions: shifter state encoding, bit-period helper and frame length.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
    localparam int unsigned FRAME_BITS = 11;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
    localparam int unsigned FRAME_BITS = 10;
`endif

    // Clock cycles per line bit (integer division, caller keeps it >= 2).
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period counter: bit_end pulses on the last cycle of every CLKS_PER_BIT-cycle period.
// restart forces the next cycle to be the first cycle of a new period.
module baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// Double-buffered byte-serial UART transmitter (8N1, or 8E1 with UART_TX_PARITY_EN defined)
// that paces its producer with one-cycle tx_ready requests.
module uart_tx #(
    parameter int unsigned CLK_HZ = 12_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);
    import uart_pkg::*;

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

    state_t     state;
    logic [7:0] hold;
    logic [7:0] shift;
    logic [2:0] bit_idx;
    logic       hold_v;
    logic       armed;
    logic       tx_en_d;
    logic       bit_end;
    logic       load_c;
    logic       capture_c;
    logic       restart_c;

    // Hand the held byte to the shifter when idle or exactly as the stop bit ends.
    assign load_c    = hold_v && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
    assign capture_c = armed && tx_en && !hold_v;
    assign restart_c = load_c || (state == ST_IDLE);
    assign tx_busy   = hold_v || (state != ST_IDLE);

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk    (clk),
        .rst    (rst),
        .restart(restart_c),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            tx_ready <= 1'b0;
            hold     <= '0;
            hold_v   <= 1'b0;
            armed    <= 1'b0;
            tx_en_d  <= 1'b0;
            shift    <= '0;
            bit_idx  <= '0;
        end else begin
            tx_en_d  <= tx_en;
            tx_ready <= load_c && tx_en;

            // Arm on burst start or after each request; drop on capture or abandoned burst.
            if ((tx_en && !tx_en_d) || tx_ready) begin
                armed <= 1'b1;
            end else if (armed && !(tx_en && hold_v)) begin
                armed <= 1'b0;
            end

            if (capture_c) begin
                hold   <= tx_data;
                hold_v <= 1'b1;
            end else if (load_c) begin
                hold_v <= 1'b0;
            end

            if (load_c) begin
                shift <= hold;
            end

            case (state)
                ST_IDLE: begin
                    if (load_c) begin
                        state <= ST_START;
                        tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state   <= ST_DATA;
                        tx      <= shift[0];
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            tx    <= ^shift;
`else
                            state <= ST_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[bit_idx + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        if (load_c) begin
                            state <= ST_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
